// File: rtl/instr_fetch_cache_pkg.sv
// Shared types and default geometry for the instruction fetch cache.
package instr_fetch_cache_pkg;

    localparam int ICACHE_ADDR_WIDTH = 32;
    localparam int ICACHE_DATA_WIDTH = 32;
    localparam int ICACHE_SETS       = 16;
    localparam int ICACHE_LINE_WORDS = 4;

    // Index widths derived from the default geometry.
    localparam int ICACHE_SET_BITS  = $clog2(ICACHE_SETS);
    localparam int ICACHE_WORD_BITS = $clog2(ICACHE_LINE_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2,
        DRAIN   = 2'd3
    } icache_state_t;

endpackage

// File: rtl/instr_fetch_cache_line_store.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// One registered lookup port, one refill word write port, one tag/valid
// write port and a global valid clear used by fence.i.
module icache_line_store
    import instr_fetch_cache_pkg::*;
#(
    parameter int TAG_W      = 24,
    parameter int DATA_W     = ICACHE_DATA_WIDTH,
    parameter int SETS       = ICACHE_SETS,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int SET_BITS   = ICACHE_SET_BITS,
    parameter int WORD_BITS  = ICACHE_WORD_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_en_i,
    input  logic [SET_BITS-1:0]  rd_set_i,
    input  logic [WORD_BITS-1:0] rd_word_i,
    output logic                 rd_valid_o,
    output logic [TAG_W-1:0]     rd_tag_o,
    output logic [DATA_W-1:0]    rd_data_o,
    input  logic                 wr_en_i,
    input  logic [SET_BITS-1:0]  wr_set_i,
    input  logic [WORD_BITS-1:0] wr_word_i,
    input  logic [DATA_W-1:0]    wr_data_i,
    input  logic                 tag_we_i,
    input  logic [SET_BITS-1:0]  tag_set_i,
    input  logic [TAG_W-1:0]     tag_i,
    input  logic                 tag_valid_i,
    input  logic                 clear_all_i
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS*LINE_WORDS];

    // Valid bits: reset and fence.i clear everything, otherwise per-set update.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (clear_all_i) begin
            valid_q <= '0;
        end else if (tag_we_i) begin
            valid_q[tag_set_i] <= tag_valid_i;
        end
    end

    // Tag array, qualified by the valid bit so it needs no reset.
    always_ff @(posedge clk) begin
        if (tag_we_i) begin
            tag_q[tag_set_i] <= tag_i;
        end
    end

    // Data array, written one refill word at a time.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[{wr_set_i, wr_word_i}] <= wr_data_i;
        end
    end

    // Registered lookup port; the result is compared in the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_o <= 1'b0;
            rd_tag_o   <= '0;
            rd_data_o  <= '0;
        end else if (rd_en_i) begin
            rd_valid_o <= valid_q[rd_set_i];
            rd_tag_o   <= tag_q[rd_set_i];
            rd_data_o  <= data_q[{rd_set_i, rd_word_i}];
        end
    end

endmodule

// File: rtl/instr_fetch_cache.sv
// Direct-mapped read-only instruction cache: 1-cycle registered hits,
// word-by-word line refill over the MMU instr port, abortable by squash
// (delete_tagged) and fence.i (flush).
//
//  state   | meaning
//  IDLE    | serve lookups; a miss on the looked-up line starts a refill
//  REQ     | mem_read high for word cnt_q, waiting for mem_ready
//  RELEASE | word captured, mem_read low, waiting for MMU to drop mem_ready
//  DRAIN   | refill aborted, waiting for MMU to drop mem_ready
module instr_fetch_cache
    import instr_fetch_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = ICACHE_ADDR_WIDTH,
    parameter int DATA_WIDTH = ICACHE_DATA_WIDTH,
    parameter int SETS       = ICACHE_SETS,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  delete_tagged,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic                  cpu_read,
    output logic                  cpu_hit,
    output logic [DATA_WIDTH-1:0] cpu_instr,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_ready
);

    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int SET_BITS  = $clog2(SETS);
    localparam int LINE_LSB  = 2 + WORD_BITS;
    localparam int LINE_W    = ADDR_WIDTH - LINE_LSB;
    localparam int TAG_W     = LINE_W - SET_BITS;
    localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(LINE_WORDS - 1);

    icache_state_t         state_q, state_d;
    logic [WORD_BITS-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [LINE_W-1:0]     look_line_q, look_line_d;
    logic                  lookup_q, lookup_d;

    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  hit_raw;
    logic                  abort;
    logic                  wr_en;
    logic                  tag_we;
    logic                  tag_valid;
    logic [LINE_W-1:0]     tag_line;

    // Fetch addresses are word aligned; the byte offset carries no information.
    logic                  unused_byte_offset;
    assign unused_byte_offset = ^cpu_address[1:0];

    assign abort    = delete_tagged | flush;
    assign hit_raw  = lookup_q & rd_valid & (rd_tag == look_line_q[LINE_W-1 -: TAG_W]);
    assign cpu_hit  = (state_q == IDLE) & hit_raw;
    assign cpu_instr = cpu_hit ? rd_data : '0;

    assign mem_read    = (state_q == REQ);
    assign mem_address = mem_read ? {line_q, cnt_q, 2'b00} : '0;

    // Miss start writes the new tag with valid=0 so the old line cannot hit
    // while its words are being overwritten; refill completion sets valid.
    assign tag_line = (state_q == IDLE) ? look_line_q : line_q;

    // Next-state, counter and array write control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        look_line_d = look_line_q;
        lookup_d    = 1'b0;
        wr_en       = 1'b0;
        tag_we      = 1'b0;
        tag_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                if (lookup_q && !hit_raw && !abort) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    line_d  = look_line_q;
                    tag_we  = 1'b1;
                end else if (cpu_read && !abort) begin
                    lookup_d    = 1'b1;
                    look_line_d = cpu_address[ADDR_WIDTH-1:LINE_LSB];
                end
            end
            REQ: begin
                if (abort) begin
                    state_d = DRAIN;
                end else if (mem_ready) begin
                    wr_en   = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (abort) begin
                    state_d = DRAIN;
                end else if (!mem_ready) begin
                    if (cnt_q == LAST_WORD) begin
                        tag_we    = 1'b1;
                        tag_valid = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = REQ;
                    end
                end
            end
            DRAIN: begin
                if (!mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            line_q      <= '0;
            look_line_q <= '0;
            lookup_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            look_line_q <= look_line_d;
            lookup_q    <= lookup_d;
        end
    end

    icache_line_store #(
        .TAG_W      (TAG_W),
        .DATA_W     (DATA_WIDTH),
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .SET_BITS   (SET_BITS),
        .WORD_BITS  (WORD_BITS)
    ) u_store (
        .clk         (clk),
        .reset       (reset),
        .rd_en_i     (lookup_d),
        .rd_set_i    (cpu_address[LINE_LSB +: SET_BITS]),
        .rd_word_i   (cpu_address[2 +: WORD_BITS]),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .wr_en_i     (wr_en),
        .wr_set_i    (line_q[SET_BITS-1:0]),
        .wr_word_i   (cnt_q),
        .wr_data_i   (mem_data),
        .tag_we_i    (tag_we),
        .tag_set_i   (tag_line[SET_BITS-1:0]),
        .tag_i       (tag_line[LINE_W-1 -: TAG_W]),
        .tag_valid_i (tag_valid),
        .clear_all_i (flush)
    );

endmodule
